pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Multi-cycle control FSM for the Redux-V fetch/PC path. Holds the architectural PC register,
//  sequences FETCH/DECODE/EXEC/UPDATE and drives the jmx/bmx selects of the next_pc datapath.
//  Loads the next_pc result into the PC once per retired instruction.
//  Sits between instruction memory, the external decoder and the execute datapath.
// PARAMETERS
//  PC_W      8   PC / address width; all PC arithmetic is modulo 2**PC_W
//  RESET_PC  0   PC value on reset
//  CNT_W     16  width of retired-instruction counter
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      level; leaves IDLE
//  imem_addr  out  PC_W   fetch address (= pc)
//  imem_req   out  1      fetch request, held until imem_ack
//  imem_ack   in   1      instruction valid this cycle
//  ir_load    out  1      1-cycle pulse: latch instruction register
//  dec_jmp    in   1      decoded absolute jump (target = reg_b)
//  dec_brz    in   1      decoded branch-if-zero (target = pc + dec_imm)
//  dec_halt   in   1      decoded halt
//  dec_imm    in   PC_W   signed branch offset, two's complement
//  reg_b      in   PC_W   register operand for jumps
//  zero_flag  in   1      ALU zero flag, sampled in EXEC on ex_done
//  ex_done    in   1      execute stage finished
//  reg_we     out  1      1-cycle register-file write pulse in UPDATE for non-jump/branch ops
//  jmx, bmx   out  1      next_pc selects, valid only in UPDATE, else 0
//  pc         out  PC_W   architectural PC
//  halted     out  1      1 in HALT
//  instr_cnt  out  CNT_W  retired instructions, wraps at 2**CNT_W
// BEHAVIOUR
//  - Reset (async): state=IDLE, pc=RESET_PC, instr_cnt=0; all pulse/select outputs and halted 0.
//    imem_req drops in the same cycle rst rises, with no pending ack honoured.
//  - States: IDLE, FETCH, DECODE, EXEC, UPDATE, HALT (plus STEP, see below).
//  - IDLE   : start=1 -> FETCH.
//  - FETCH  : imem_req=1. On imem_ack: ir_load=1 the same cycle, then -> DECODE. No timeout.
//  - DECODE : one cycle; registers dec_* and reg_b. dec_halt -> HALT (pc not advanced, not counted).
//    Otherwise -> EXEC.
//  - EXEC   : waits for ex_done, then -> UPDATE. take_br = dec_brz & zero_flag, latched on ex_done.
//  - UPDATE : one cycle. Select rules:
//      dec_jmp           -> bmx=1, jmx=0 (pc <= reg_b)
//      take_br           -> jmx=1, bmx=0 (pc <= pc + dec_imm)
//      neither           -> both 0 (pc <= pc + 1)
//      dec_jmp & dec_brz -> jump wins; bmx never coexists with jmx
//    reg_we=1 only when neither dec_jmp nor dec_brz is set. instr_cnt++. -> FETCH.
//  - HALT   : sticky; start is ignored; only rst exits.
//  - Minimum latency is 4 cycles per instruction (ack and ex_done both immediate).
//  - Wrap: pc=255 + 1 -> 0; pc=0 + imm(-4) -> 252. Offsets are sign-extended to PC_W.
// CONFIGURATION
//  - SINGLE_STEP_EN defined: adds input step (1 bit). UPDATE -> STEP instead of FETCH.
//    STEP holds until a step=1 cycle, then -> FETCH. A step pulse in any other state is ignored.
//  - SINGLE_STEP_EN undefined: no step port, no STEP state; UPDATE -> FETCH directly.
// STRUCTURE
//  - pc_seq_defs.vh: state encodings (localparam), select encodings, PC_W default.
//  - Sub-module: the existing next_pc, instantiated once and fed by pc, dec_imm, reg_b, jmx, bmx.
//    Its n_pc is registered into pc in UPDATE. The sequencer contains no separate adder.
// TESTING
//  1. Reset mid-FETCH (imem_req=1, rst pulse) -> imem_req=0 the same cycle; pc=0, state IDLE.
//  2. Straight-line: start, 3 non-branch instrs with ack/ex_done immediate ->
//     pc 0->1->2->3, reg_we x3, instr_cnt=3, 12 cycles.
//  3. Branch taken: pc=120, dec_brz=1, dec_imm=6, zero_flag=1 -> jmx=1 in UPDATE, pc=126, reg_we=0.
//     Same with zero_flag=0 -> pc=121.
//  4. Jump + wrap: dec_jmp=1, reg_b=55 -> bmx=1, pc=55.
//     pc=0, dec_brz taken, dec_imm=-4 -> pc=252.
//  5. Stalls and halt: imem_ack delayed 3 cycles, ex_done delayed 2 -> imem_req held, no extra ir_load.
//     Then dec_halt -> halted=1, pc unchanged, start ignored.
//  6. SINGLE_STEP_EN: after each UPDATE the FSM waits in STEP; pc advances exactly once per step pulse.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared state/select encodings for the Redux-V PC sequencer.
// Latency: n/a (types only). Backpressure: n/a.
// The next-PC select encoding maps bit 0 to jmx and bit 1 to bmx.
package pc_sequencer_pkg;

    localparam int PC_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_UPDATE = 3'd4,
        ST_HALT   = 3'd5,
        ST_STEP   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        NXT_INC = 2'b00,
        NXT_BR  = 2'b01,
        NXT_JMP = 2'b10
    } nxt_sel_t;

    // Jump wins over a taken branch, so both selects can never be high together.
    function automatic nxt_sel_t next_sel(input logic jmp, input logic take_br);
        nxt_sel_t sel;
        sel = NXT_INC;
        if (jmp) begin
            sel = NXT_JMP;
        end else if (take_br) begin
            sel = NXT_BR;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pc_sequencer_next_pc.sv
// Next-PC datapath: selects reg_b (bmx), pc + signed offset (jmx) or pc + 1.
// Latency: combinational. Backpressure: none.
// All arithmetic wraps modulo 2**PC_W.
module pc_sequencer_next_pc #(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] dec_imm,
    input  logic [PC_W-1:0] reg_b,
    input  logic            jmx,
    input  logic            bmx,
    output logic [PC_W-1:0] n_pc
);

    always_comb begin
        n_pc = pc + PC_W'(1);
        if (bmx) begin
            n_pc = reg_b;
        end else if (jmx) begin
            n_pc = pc + dec_imm;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Redux-V fetch/PC control FSM: FETCH/DECODE/EXEC/UPDATE, owns the architectural PC.
// Latency: 4 cycles per instruction minimum; stalls on imem_ack and ex_done (request held, no timeout).
// SINGLE_STEP_EN adds a step input and a STEP state that gates each new fetch.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic [PC_W-1:0]  imem_addr,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_load,
    input  logic             dec_jmp,
    input  logic             dec_brz,
    input  logic             dec_halt,
    input  logic [PC_W-1:0]  dec_imm,
    input  logic [PC_W-1:0]  reg_b,
    input  logic             zero_flag,
    input  logic             ex_done,
    output logic             reg_we,
    output logic             jmx,
    output logic             bmx,
    output logic [PC_W-1:0]  pc,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t          state;
    nxt_sel_t        sel_q;
    logic            jmp_q;
    logic            brz_q;
    logic [PC_W-1:0] imm_q;
    logic [PC_W-1:0] rb_q;
    logic [PC_W-1:0] n_pc;

    assign imem_addr = pc;
    // imem_req is only ever high in FETCH, so this gates ack to the fetch window.
    assign ir_load   = imem_req & imem_ack;
    assign jmx       = sel_q[0];
    assign bmx       = sel_q[1];

    pc_sequencer_next_pc #(.PC_W(PC_W)) u_next_pc (
        .pc      (pc),
        .dec_imm (imm_q),
        .reg_b   (rb_q),
        .jmx     (jmx),
        .bmx     (bmx),
        .n_pc    (n_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            instr_cnt <= '0;
            imem_req  <= 1'b0;
            sel_q     <= NXT_INC;
            reg_we    <= 1'b0;
            halted    <= 1'b0;
            jmp_q     <= 1'b0;
            brz_q     <= 1'b0;
            imm_q     <= '0;
            rb_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        state    <= ST_DECODE;
                        imem_req <= 1'b0;
                    end
                end
                ST_DECODE: begin
                    jmp_q <= dec_jmp;
                    brz_q <= dec_brz;
                    imm_q <= dec_imm;
                    rb_q  <= reg_b;
                    if (dec_halt) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // zero_flag only matters in the ex_done cycle
                    if (ex_done) begin
                        state  <= ST_UPDATE;
                        sel_q  <= next_sel(jmp_q, brz_q & zero_flag);
                        reg_we <= ~(jmp_q | brz_q);
                    end
                end
                ST_UPDATE: begin
                    pc        <= n_pc;
                    instr_cnt <= instr_cnt + CNT_W'(1);
                    sel_q     <= NXT_INC;
                    reg_we    <= 1'b0;
`ifdef SINGLE_STEP_EN
                    state     <= ST_STEP;
`else
                    state     <= ST_FETCH;
                    imem_req  <= 1'b1;
`endif
                end
`ifdef SINGLE_STEP_EN
                ST_STEP: begin
                    if (step) begin
                        state    <= ST_FETCH;
                        imem_req <= 1'b1;
                    end
                end
`endif
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table plus randomized instruction stream
// checked against an instruction-level reference model. Honors SINGLE_STEP_EN when defined.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, imem_ack, dec_jmp, dec_brz, dec_halt, zero_flag, ex_done;
    logic [7:0]  dec_imm, reg_b;
    logic [7:0]  imem_addr, pc;
    logic        imem_req, ir_load, reg_we, jmx, bmx, halted;
    logic [15:0] instr_cnt;
`ifdef SINGLE_STEP_EN
    logic        step = 1'b0;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [7:0]  m_pc;
    int          m_cnt;

    always #5 clk = ~clk;

    pc_sequencer #(.PC_W(8), .RESET_PC(8'd0), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef SINGLE_STEP_EN
        .step      (step),
`endif
        .imem_addr (imem_addr),
        .imem_req  (imem_req),
        .imem_ack  (imem_ack),
        .ir_load   (ir_load),
        .dec_jmp   (dec_jmp),
        .dec_brz   (dec_brz),
        .dec_halt  (dec_halt),
        .dec_imm   (dec_imm),
        .reg_b     (reg_b),
        .zero_flag (zero_flag),
        .ex_done   (ex_done),
        .reg_we    (reg_we),
        .jmx       (jmx),
        .bmx       (bmx),
        .pc        (pc),
        .halted    (halted),
        .instr_cnt (instr_cnt)
    );

    typedef struct {
        logic       jmp;
        logic       brz;
        logic [7:0] imm;
        logic [7:0] rb;
        logic       z;
        logic [7:0] exp_pc;
        logic       exp_jmx;
        logic       exp_bmx;
        logic       exp_we;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Architectural next-PC rule, 8-bit wrap.
    function automatic logic [7:0] ref_next(input logic [7:0] p, input logic jmp, input logic brz,
                                            input logic z, input logic [7:0] imm, input logic [7:0] rb);
        logic [8:0] sum;
        if (jmp) return rb;
        if (brz && z) begin
            sum = {1'b0, p} + {1'b0, imm};
            return sum[7:0];
        end
        sum = {1'b0, p} + 9'd1;
        return sum[7:0];
    endfunction

    task automatic scramble_dec();
        dec_jmp = 1'($urandom);
        dec_brz = 1'($urandom);
        dec_halt = 1'($urandom);
        dec_imm = 8'($urandom);
        reg_b   = 8'($urandom);
    endtask

    // Entered with the DUT in FETCH, sampled just after a rising edge.
    task automatic run_instr(input logic jmp, input logic brz, input logic halt,
                             input logic [7:0] imm, input logic [7:0] rb, input logic z,
                             input int ack_dly, input int ex_dly,
                             input logic [7:0] exp_pc, input logic exp_jmx,
                             input logic exp_bmx, input logic exp_we);
        check("fetch_req", imem_req, 1);
        check("fetch_addr", imem_addr, m_pc);
        for (int k = 0; k < ack_dly; k++) begin
            imem_ack = 1'b0;
            scramble_dec();
            #1;
            check("stall_irload", ir_load, 0);
            check("stall_req", imem_req, 1);
            tick();
        end
        imem_ack = 1'b1;
        dec_jmp = jmp; dec_brz = brz; dec_halt = halt; dec_imm = imm; reg_b = rb;
        #1;
        check("ack_irload", ir_load, 1);
        tick();
        imem_ack = 1'b0;
        #1;
        check("decode_irload", ir_load, 0);
        check("decode_req", imem_req, 0);
        tick();
        scramble_dec();
        if (halt) begin
            check("halted", halted, 1);
            check("halt_pc", pc, m_pc);
            check("halt_cnt", instr_cnt, m_cnt);
            return;
        end
        check("not_halted", halted, 0);
        for (int k = 0; k < ex_dly; k++) begin
            ex_done = 1'b0;
            zero_flag = ~z;
`ifdef SINGLE_STEP_EN
            step = 1'($urandom);
`endif
            check("exec_sel", {30'd0, jmx, bmx}, 0);
            tick();
        end
`ifdef SINGLE_STEP_EN
        step = 1'b0;
`endif
        ex_done = 1'b1;
        zero_flag = z;
        tick();
        ex_done = 1'b0;
        zero_flag = ~z;
        check("upd_jmx", jmx, exp_jmx);
        check("upd_bmx", bmx, exp_bmx);
        check("upd_reg_we", reg_we, exp_we);
        check("upd_pc_old", pc, m_pc);
        tick();
        m_pc = exp_pc;
        m_cnt++;
        check("retire_pc", pc, m_pc);
        check("retire_cnt", instr_cnt, m_cnt);
        check("retire_sel", {29'd0, jmx, bmx, reg_we}, 0);
`ifdef SINGLE_STEP_EN
        for (int k = 0; k < 3; k++) begin
            check("step_wait_req", imem_req, 0);
            check("step_wait_pc", pc, m_pc);
            tick();
        end
        step = 1'b1;
        tick();
        step = 1'b0;
`endif
    endtask

    initial begin
        int c0;
        logic jmp, brz, z;
        logic [7:0] imm, rb;

        tbl[0]  = '{1'b1, 1'b0, 8'd0,   8'd120, 1'b0, 8'd120, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'd6,   8'd9,   1'b1, 8'd126, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'd0,   8'd120, 1'b1, 8'd120, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'd6,   8'd9,   1'b0, 8'd121, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 8'd3,   8'd55,  1'b0, 8'd55,  1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 8'd3,   8'd0,   1'b0, 8'd0,   1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 8'hFC,  8'd17,  1'b1, 8'd252, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 8'd3,   8'd255, 1'b1, 8'd255, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'd9,   8'd9,   1'b1, 8'd0,   1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 8'h7F,  8'd1,   1'b1, 8'd127, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 8'h80,  8'd1,   1'b1, 8'd255, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; imem_ack = 1'b0; ex_done = 1'b0; zero_flag = 1'b0;
        dec_jmp = 1'b0; dec_brz = 1'b0; dec_halt = 1'b0; dec_imm = 8'd0; reg_b = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc, 0);
        check("rst_cnt", instr_cnt, 0);
        check("rst_req", imem_req, 0);
        check("rst_outs", {28'd0, ir_load, reg_we, jmx, bmx}, 0);
        check("rst_halted", halted, 0);
        rst = 1'b0;
        tick();
        check("idle_req", imem_req, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        m_pc = 8'd0;
        m_cnt = 0;

        // Straight-line, zero stall: 4 cycles per instruction
        c0 = cyc;
        for (int i = 0; i < 3; i++)
            run_instr(1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 0, 0,
                      8'(i + 1), 1'b0, 1'b0, 1'b1);
`ifndef SINGLE_STEP_EN
        check("straight_cycles", cyc - c0, 12);
`endif
        check("straight_pc", pc, 3);
        check("straight_cnt", instr_cnt, 3);

        for (int i = 0; i < 11; i++)
            run_instr(tbl[i].jmp, tbl[i].brz, 1'b0, tbl[i].imm, tbl[i].rb, tbl[i].z,
                      int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                      tbl[i].exp_pc, tbl[i].exp_jmx, tbl[i].exp_bmx, tbl[i].exp_we);

        // Long stalls: taken branch from 255 wraps to 39
        run_instr(1'b0, 1'b1, 1'b0, 8'd40, 8'd0, 1'b1, 3, 2, 8'd39, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a fetch with ack pending
        check("prereset_req", imem_req, 1);
        imem_ack = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_req", imem_req, 0);
        check("arst_irload", ir_load, 0);
        check("arst_pc", pc, 0);
        check("arst_cnt", instr_cnt, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("post_rst_req", imem_req, 0);
            check("post_rst_irload", ir_load, 0);
        end
        imem_ack = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        m_pc = 8'd0;
        m_cnt = 0;

        for (int i = 0; i < 150; i++) begin
            jmp = ($urandom_range(0, 3) == 0);
            brz = ($urandom_range(0, 2) == 0);
            z   = 1'($urandom);
            imm = 8'($urandom);
            rb  = 8'($urandom);
            run_instr(jmp, brz, 1'b0, imm, rb, z,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      ref_next(m_pc, jmp, brz, z, imm, rb),
                      !jmp && brz && z, jmp, !jmp && !brz);
        end

        // Halt after a stalled fetch; start must not wake it
        run_instr(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 3, 0, m_pc, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        for (int k = 0; k < 6; k++) begin
`ifdef SINGLE_STEP_EN
            step = 1'($urandom);
`endif
            tick();
            check("halt_sticky", halted, 1);
            check("halt_req", imem_req, 0);
            check("halt_pc_hold", pc, m_pc);
            check("halt_cnt_hold", instr_cnt, m_cnt);
        end
        start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
